online_collector_r4: RTL

- Receiving end of the radix-4 online digit stream: consumes MSD-first signed digits from online_adder_r4 and assembles the result.
- Discards the leading online-delay digits.
- Produces the two's-complement value by on-the-fly (OTF) conversion, with no final carry-propagate addition.
- Also keeps the raw digit vector, so benches compare against tester_r4 expected values in hardware.

---
 rtl/online_r4_pkg.sv | 30 +++
 rtl/otf_step_r4.sv | 47 ++++
 rtl/online_collector_r4.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/online_r4_pkg.sv
// ---------------------------------------------------------------------------
// online_r4_pkg
// Shared definitions for the radix-4 online digit datapath: digit width and
// type, legal digit range, collector FSM states and the result-width helper.
// Optional feature macro used by importers: ONLINE_DIGIT_CHECK_EN.
// ---------------------------------------------------------------------------
package online_r4_pkg;

  // Bits per signed digit; digits are two's complement in -3..+3
  localparam int C = 3;

  typedef logic signed [C-1:0] digit_t;

  localparam int DIGIT_MAX = 3;
  localparam int DIGIT_MIN = -3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_COLLECT,
    ST_DONE
  } state_t;

  // A radix-4 value with ndig digits of magnitude <= 3 needs 2*ndig bits of
  // magnitude plus a sign bit.
  function automatic int result_width(input int ndig);
    return 2 * ndig + 1;
  endfunction

endpackage

// File: rtl/otf_step_r4.sv
// ---------------------------------------------------------------------------
// otf_step_r4
// One combinational on-the-fly conversion step for radix-4 signed digits.
// Q holds the converted prefix, QM holds Q - 1, so a negative digit never
// needs a borrow to ripple through the already converted bits.
// Ports:
//   q_i   - current Q (W bits, signed)
//   qm_i  - current QM = Q - 1 (W bits, signed)
//   d_i   - incoming digit (-3..+3)
//   q_o   - next Q
//   qm_o  - next QM
// ---------------------------------------------------------------------------
module otf_step_r4
  import online_r4_pkg::*;
#(
  parameter int W = 15
) (
  input  logic signed [W-1:0] q_i,
  input  logic signed [W-1:0] qm_i,
  input  digit_t              d_i,
  output logic signed [W-1:0] q_o,
  output logic signed [W-1:0] qm_o
);

  localparam logic signed [W-1:0] ONE   = W'(1);
  localparam logic signed [W-1:0] THREE = W'(3);
  localparam logic signed [W-1:0] FOUR  = W'(4);

  logic signed [W-1:0] dExt;
  logic signed [W-1:0] q4;
  logic signed [W-1:0] qm4;
  logic                dNeg;
  logic                dPos;

  // Append the digit to both candidate prefixes. A negative digit selects
  // the QM branch with a borrow already folded into 4+d / 3+d.
  always_comb begin
    dExt = {{(W-C){d_i[C-1]}}, d_i};
    q4   = q_i <<< 2;
    qm4  = qm_i <<< 2;
    dNeg = d_i[C-1];
    dPos = !d_i[C-1] && (d_i != '0);
    q_o  = dNeg ? (qm4 + dExt + FOUR) : (q4 + dExt);
    qm_o = dPos ? (q4 + dExt - ONE) : (qm4 + dExt + THREE);
  end

endmodule

// File: rtl/online_collector_r4.sv
// ---------------------------------------------------------------------------
// online_collector_r4
// Receiving end of a radix-4 online digit stream. After start, drops the
// first SKIP valid digits (online delay), then assembles NDIG MSD-first
// signed digits into a two's-complement result by on-the-fly conversion and
// also keeps the raw digit vector.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   en              - global enable, all state holds when low
//   start           - one-cycle pulse starting a new word (aborts any word)
//   zi_valid, zi    - incoming digit and its qualifier
//   busy            - word in progress (skip or collect phase)
//   done            - one-cycle pulse, result/digits final
//   result          - sum of d_j * 4^(NDIG-j)
//   digits          - raw digits, first collected digit in MS field
//   err             - sticky illegal-digit (-4) flag
// Optional feature: define ONLINE_DIGIT_CHECK_EN to enable the -4 digit
// check and saturation; otherwise err is tied low.
// ---------------------------------------------------------------------------
module online_collector_r4
  import online_r4_pkg::*;
#(
  parameter  int NDIG = 7,
  parameter  int SKIP = 2,
  localparam int W    = result_width(NDIG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                start,
  input  logic                zi_valid,
  input  digit_t              zi,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] result,
  output logic [NDIG*C-1:0]   digits,
  output logic                err
);

  localparam int CW = $clog2(NDIG + SKIP + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic signed [W-1:0] q_q, qm_q;
  logic signed [W-1:0] qNext, qmNext;
  logic signed [W-1:0] result_q;
  logic [NDIG*C-1:0]   digits_q;
  logic                done_q;
  logic                skipLast;
  logic                collectLast;
  digit_t              dEff;

`ifdef ONLINE_DIGIT_CHECK_EN
  logic illegalDigit;
  logic err_q;

  // A -4 digit is flagged and folded to -3 so the conversion stays in range.
  always_comb begin
    illegalDigit = (zi == digit_t'(DIGIT_MIN - 1));
    dEff         = illegalDigit ? digit_t'(DIGIT_MIN) : zi;
  end

  // Sticky error flag; only digits seen while collecting are inspected.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (en) begin
      if (start) begin
        err_q <= 1'b0;
      end else if (state_q == ST_COLLECT && zi_valid && illegalDigit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign dEff = zi;
  assign err  = 1'b0;
`endif

  otf_step_r4 #(
    .W(W)
  ) uOtf (
    .q_i  (q_q),
    .qm_i (qm_q),
    .d_i  (dEff),
    .q_o  (qNext),
    .qm_o (qmNext)
  );

  // Phase-end decodes: the counter is reused for the skip and collect phases.
  always_comb begin
    skipLast    = zi_valid && (cnt_q == CW'(SKIP - 1));
    collectLast = zi_valid && (cnt_q == CW'(NDIG - 1));
  end

  // State register; en low freezes the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start from any state restarts the word.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (SKIP > 0) ? ST_SKIP : ST_COLLECT;
    end else begin
      case (state_q)
        ST_SKIP:    if (skipLast)    state_d = ST_COLLECT;
        ST_COLLECT: if (collectLast) state_d = ST_DONE;
        default:    state_d = state_q;
      endcase
    end
  end

  // Outputs decoded from state; done is masked while the block is disabled.
  always_comb begin
    busy = (state_q == ST_SKIP) || (state_q == ST_COLLECT);
    done = done_q && en;
  end

  // Datapath: counter, OTF registers, raw digit shifter and the final result
  // capture. The result is taken from the OTF output of the last digit so
  // done appears on the clock right after that digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      q_q      <= '0;
      qm_q     <= {W{1'b1}};
      result_q <= '0;
      digits_q <= '0;
      done_q   <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      if (start) begin
        cnt_q    <= '0;
        q_q      <= '0;
        qm_q     <= {W{1'b1}};
        digits_q <= '0;
      end else begin
        case (state_q)
          ST_SKIP: begin
            if (zi_valid) begin
              cnt_q <= skipLast ? '0 : cnt_q + 1'b1;
            end
          end
          ST_COLLECT: begin
            if (zi_valid) begin
              q_q      <= qNext;
              qm_q     <= qmNext;
              digits_q <= {digits_q[NDIG*C-C-1:0], zi};
              cnt_q    <= cnt_q + 1'b1;
              if (collectLast) begin
                result_q <= qNext;
                done_q   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign result = result_q;
  assign digits = digits_q;

endmodule
